// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: a level request with its access
// fields, answered by a grant pulse and a read-data-valid pulse.
interface dmem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer for the single-port data memory. Accesses are
// serialised through IDLE -> ACC (-> WAIT for reads) with every output registered.
module dmem_arbiter #(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave r0,
  dmem_arbiter_if.slave r1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_mw,
  input  logic [DW-1:0] mem_q,
  output logic          busy
);
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ACC       = 2'd1;
  localparam logic [1:0] WAIT      = 2'd2;
  localparam logic [1:0] WAIT_INIT = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

  logic [1:0]         state_reg;
  logic [1:0]         cnt_reg;
  logic               last_reg;
  logic               win_reg;
  logic               we_reg;
  logic [1:0]         gnt_reg;
  logic [1:0]         rvalid_reg;
  logic [1:0][DW-1:0] rdata_reg;
  logic [AW-1:0]      mem_addr_reg;
  logic [DW-1:0]      mem_data_reg;
  logic               mem_mw_reg;
  logic               busy_reg;

  logic [1:0]    req;
  logic          win_next;
  logic          we_sel;
  logic [AW-1:0] addr_sel;
  logic [DW-1:0] wdata_sel;

  assign req = {r1.req, r0.req};
  // A tie goes to the requester that was not served last; otherwise the sole requester wins.
  assign win_next  = (req == 2'b11) ? ~last_reg : req[1];
  assign we_sel    = win_next ? r1.we    : r0.we;
  assign addr_sel  = win_next ? r1.addr  : r0.addr;
  assign wdata_sel = win_next ? r1.wdata : r0.wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 2'd0;
      last_reg     <= 1'b1;
      win_reg      <= 1'b0;
      we_reg       <= 1'b0;
      gnt_reg      <= 2'b00;
      rvalid_reg   <= 2'b00;
      rdata_reg    <= '0;
      mem_addr_reg <= '0;
      mem_data_reg <= '0;
      mem_mw_reg   <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      gnt_reg    <= 2'b00;
      rvalid_reg <= 2'b00;
      case (state_reg)
        IDLE: begin
          if (req != 2'b00) begin
            win_reg           <= win_next;
            last_reg          <= win_next;
            we_reg            <= we_sel;
            mem_addr_reg      <= addr_sel;
            mem_data_reg      <= wdata_sel;
            mem_mw_reg        <= we_sel;
            gnt_reg[win_next] <= 1'b1;
            busy_reg          <= 1'b1;
            state_reg         <= ACC;
          end
        end
        ACC: begin
          mem_mw_reg <= 1'b0;
          if (we_reg) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (RD_LAT == 0) begin
            rdata_reg[win_reg]  <= mem_q;
            rvalid_reg[win_reg] <= 1'b1;
            state_reg           <= IDLE;
            busy_reg            <= 1'b0;
          end else begin
            cnt_reg   <= WAIT_INIT;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          // Address stays on the memory until the counted latency has elapsed.
          if (cnt_reg == 2'd0) begin
            rdata_reg[win_reg]  <= mem_q;
            rvalid_reg[win_reg] <= 1'b1;
            state_reg           <= IDLE;
            busy_reg            <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 2'd1;
          end
        end
        default: begin
          state_reg  <= IDLE;
          mem_mw_reg <= 1'b0;
          busy_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign r0.gnt    = gnt_reg[0];
  assign r1.gnt    = gnt_reg[1];
  assign r0.rvalid = rvalid_reg[0];
  assign r1.rvalid = rvalid_reg[1];
  assign r0.rdata  = rdata_reg[0];
  assign r1.rdata  = rdata_reg[1];
  assign mem_addr  = mem_addr_reg;
  assign mem_data  = mem_data_reg;
  assign mem_mw    = mem_mw_reg;
  assign busy      = busy_reg;
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter and sequencer for the single-port data memory (the 8-bit address/data RAM that also holds the memory-mapped IO ports). It serialises accesses from requester 0 (CPU load/store path) and requester 1 (debug/loader port) with round-robin fairness. It drives the memory address, write data and write strobe from a registered state machine. It returns read data to the winning requester with a one-cycle valid pulse.

Parameters:
AW, 8, address width
DW, 8, data width
RD_LAT, 1, memory read latency in cycles after the access cycle (legal range 0..3)

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous active-high reset
REQ0  input  1  requester 0 access request (level)
WE0  input  1  requester 0: 1 = write, 0 = read
ADDR0  input  AW  requester 0 address
WDATA0  input  DW  requester 0 write data
GNT0  output  1  requester 0 grant pulse
RVALID0  output  1  requester 0 read-data-valid pulse
RDATA0  output  DW  requester 0 read data
REQ1, WE1, ADDR1, WDATA1, GNT1, RVALID1, RDATA1  same as above, for requester 1
MEM_ADDR  output  AW  to data memory ADDR
MEM_DATA  output  DW  to data memory DATA
MEM_MW  output  1  to data memory write enable
MEM_Q  input  DW  data memory read output
BUSY  output  1  high whenever state != IDLE

Behaviour:
- All outputs are registered. On RESET, the following take effect immediately and asynchronously: state=IDLE, GNTx=0, RVALIDx=0, RDATAx=0, MEM_ADDR=0, MEM_DATA=0, MEM_MW=0, BUSY=0, LAST=1, where LAST is the index of the last-served requester.
- States: IDLE, ACC, WAIT.
- IDLE:
  - REQ/WE/ADDR/WDATA are sampled only in IDLE.
  - No REQ: stay in IDLE.
  - One REQ: that requester wins.
  - Both REQ: the requester != LAST wins.
  - On the edge, register the winner's ADDR->MEM_ADDR and WDATA->MEM_DATA, set MEM_MW=WE, set GNTwinner=1, set LAST=winner, go to ACC.
- ACC (one cycle):
  - GNT is high for exactly this cycle.
  - MEM_MW is high only in this cycle, and only for writes; the memory commits on the edge ending ACC.
  - Write: go to IDLE, clearing MEM_MW and GNT. A write occupies 2 cycles.
  - Read with RD_LAT=0: capture MEM_Q into RDATAwinner at the end of ACC and go to IDLE.
  - Read with RD_LAT>0: go to WAIT with a counter of RD_LAT-1.
- WAIT:
  - MEM_ADDR is held and MEM_MW=0.
  - The counter decrements each cycle.
  - At counter 0, capture MEM_Q into RDATAwinner and go to IDLE.
- RVALIDwinner is high for the single cycle after the capture edge. That cycle may overlap the next IDLE arbitration.
- RDATAx holds its value until the next read completes for the same requester.
- Read latency, from the cycle GNT is high to the cycle RVALID is high, is RD_LAT+1 cycles.
- Requester protocol: hold REQ, WE, ADDR and WDATA stable until GNT is seen.
- Boundary and corner cases:
  - REQ deasserted before being sampled in IDLE: no access is performed and no GNT is issued.
  - REQ still high in the IDLE after its own GNT: treated as a new request. If the other requester is also requesting, the other one wins, because LAST points to the requester just served.
  - Simultaneous first requests after reset: requester 0 wins (LAST=1).
  - RESET during ACC: MEM_MW drops immediately, and the write is not guaranteed.
  - RESET during WAIT: no RVALID is issued and RDATA is cleared.
  - No combinational path from REQx to GNTx or MEM_*.
  - A requester never sees GNT and RVALID for different transactions in an ambiguous order: each read's RVALID precedes that requester's next GNT.

Test Plan:
- Reset, then REQ0=1, WE0=1, ADDR0=8'h10, WDATA0=8'hA5 for one request -> GNT0 high 1 cycle later for 1 cycle; MEM_MW=1, MEM_ADDR=8'h10, MEM_DATA=8'hA5 in that same cycle; BUSY=1 for 1 cycle; the memory model holds A5 at 8'h10.
- RD_LAT=1: REQ1 read of ADDR1=8'h10 after the above -> GNT1 at cycle t; MEM_MW=0 throughout; RVALID1 at t+2 with RDATA1=8'hA5; RDATA0 unchanged at 8'h00.
- Both requesters hold REQ for continuous reads from reset -> grants alternate 0,1,0,1; each requester gets exactly 4 grants in the first 8 transactions; no cycle has GNT0 and GNT1 both high.
- Sweep RD_LAT=0,1,3 with a read of a preloaded 8'h3C -> RVALID arrives exactly RD_LAT+1 cycles after GNT, with data 8'h3C.
- REQ0 pulsed for 1 cycle while the arbiter is in ACC serving requester 1 -> no GNT0 and no extra memory access.
- Assert RESET asynchronously mid-ACC of a write and mid-WAIT of a read -> MEM_MW, GNTx, RVALIDx and BUSY read 0 before the next CLK edge; after release, the first tied request is granted to requester 0.
